// File: rtl/wb_uart_tracer_pkg.sv
// Shared definitions for the write-back UART tracer: transmitter states,
// entry/frame geometry and UART line levels.
package wb_uart_tracer_pkg;

    localparam int FRAME_BYTES = 5;
    localparam int ENTRY_W     = 37;

    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;
    localparam logic UART_IDLE  = 1'b1;

    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);
    localparam logic [2:0] LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Byte idx of an entry's frame: dest first, then data most-significant byte first.
    function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] entry,
                                              input logic [2:0]         idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = {3'b000, entry[36:32]};
            3'd1:    b = entry[31:24];
            3'd2:    b = entry[23:16];
            3'd3:    b = entry[15:8];
            3'd4:    b = entry[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wb_uart_tracer_fifo.sv
// trace_fifo: synchronous circular buffer; a push into a full buffer is
// accepted only when a pop retires the head in the same cycle.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Accept/retire decisions and the occupancy after this edge.
    always_comb begin
        pop_ok_s  = pop && (count_r != CNT_ZERO);
        push_ok_s = push && ((count_r != CNT_FULL) || pop_ok_s);
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_s = count_r + CNT_ONE;
            2'b01:   count_s = count_r - CNT_ONE;
            default: count_s = count_r;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_s;
        end
    end

    // Storage; when full, the write lands on the slot being popped this edge.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout      = mem_r[rd_ptr_r];
    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == CNT_ZERO);
    assign count     = count_r;
    assign count_nxt = count_s;

endmodule

// File: rtl/wb_uart_tracer.sv
// Captures committed register writes and streams each as a 5-byte 8N1 UART
// frame; entries wait in trace_fifo while a frame is on the line.
module wb_uart_tracer
    import wb_uart_tracer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wb_valid,
    input  logic [4:0]                    wb_dest,
    input  logic [31:0]                   wb_data,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e          state_r, state_s;
    logic [15:0]        clk_cnt_r, clk_cnt_s;
    logic [2:0]         bit_cnt_r, bit_cnt_s;
    logic [2:0]         byte_cnt_r, byte_cnt_s;
    logic [ENTRY_W-1:0] hold_r, hold_s;
    logic [7:0]         cur_byte_s;
    logic               tx_r, tx_s;
    logic               busy_r;
    logic               overflow_r;
    logic               push_s, pop_s, drop_s;
    logic [ENTRY_W-1:0] fifo_dout_s;
    logic               fifo_full_s, fifo_empty_s;
    logic [CW-1:0]      fifo_cnt_s, fifo_cnt_nxt_s;

    trace_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .din       ({wb_dest, wb_data}),
        .dout      (fifo_dout_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_cnt_s),
        .count_nxt (fifo_cnt_nxt_s)
    );

    // Capture filter: register 0 is never traced; a full FIFO with no pop drops.
    always_comb begin
        push_s = wb_valid && (wb_dest != 5'd0);
        drop_s = push_s && fifo_full_s && !pop_s;
    end

    // Transmitter next-state, counters and hold register.
    always_comb begin
        state_s    = state_r;
        clk_cnt_s  = clk_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        byte_cnt_s = byte_cnt_r;
        hold_s     = hold_r;
        pop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    hold_s     = fifo_dout_s;
                    clk_cnt_s  = 16'd0;
                    bit_cnt_s  = 3'd0;
                    byte_cnt_s = 3'd0;
                    state_s    = START;
                end else begin
                    state_s    = IDLE;
                end
            end
            START: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_s = 16'd0;
                    bit_cnt_s = 3'd0;
                    state_s   = DATA;
                end else begin
                    clk_cnt_s = clk_cnt_r + 16'd1;
                end
            end
            DATA: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_s = 16'd0;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_s = STOP;
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + 16'd1;
                end
            end
            STOP: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_s = 16'd0;
                    if (byte_cnt_r == LAST_BYTE) begin
                        byte_cnt_s = 3'd0;
                        state_s    = IDLE;
                    end else begin
                        byte_cnt_s = byte_cnt_r + 3'd1;
                        state_s    = START;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + 16'd1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, so tx leaves a flop with no glitches.
    always_comb begin
        cur_byte_s = frame_byte(hold_s, byte_cnt_s);
        case (state_s)
            IDLE:    tx_s = UART_IDLE;
            START:   tx_s = UART_START;
            DATA:    tx_s = cur_byte_s[bit_cnt_s];
            STOP:    tx_s = UART_STOP;
            default: tx_s = UART_IDLE;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            clk_cnt_r  <= 16'd0;
            bit_cnt_r  <= 3'd0;
            byte_cnt_r <= 3'd0;
            hold_r     <= {ENTRY_W{1'b0}};
            tx_r       <= UART_IDLE;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            clk_cnt_r  <= clk_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            byte_cnt_r <= byte_cnt_s;
            hold_r     <= hold_s;
            tx_r       <= tx_s;
            busy_r     <= (state_s != IDLE) || (fifo_cnt_nxt_s != CW'(0));
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign overflow   = overflow_r;
    assign fifo_count = fifo_cnt_s;

endmodule

// File: tb/tb_wb_uart_tracer.sv
// Self-checking bench: a queue-based model of capture, FIFO and serial line,
// compared every cycle, plus directed literal checks of frames and timing.
module tb_wb_uart_tracer;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_dest = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        tx, busy, overflow;
    logic [2:0]  fifo_count;

    wb_uart_tracer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model state
    logic [36:0] m_q[$];
    logic        m_wave[$];
    logic        m_tx = 1'b1;
    logic        m_idle = 1'b1;
    logic        m_ovf = 1'b0;

    logic        rec_tx [0:4095];
    logic        rec_busy [0:4095];
    int          rec_n = 0;
    logic [7:0]  dec_q[$];

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_wave.delete();
        m_tx = 1'b1;
        m_idle = 1'b1;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [4:0] d, input logic [31:0] x);
        logic        hit, pop, acc;
        logic [36:0] e;
        logic [39:0] fr;
        logic [7:0]  b;
        hit = v && (d != 5'd0);
        pop = m_idle && (m_q.size() > 0);
        acc = hit && ((m_q.size() < DEPTH) || pop);
        if (hit && !acc) m_ovf = 1'b1;
        if (pop) begin
            e = m_q.pop_front();
            fr = {3'b000, e};
            for (int k = 0; k < 5; k++) begin
                b = fr[39-8*k -: 8];
                repeat (CPB) m_wave.push_back(1'b0);
                for (int bi = 0; bi < 8; bi++) repeat (CPB) m_wave.push_back(b[bi]);
                repeat (CPB) m_wave.push_back(1'b1);
            end
        end
        if (acc) m_q.push_back({d, x});
        if (m_wave.size() > 0) begin
            m_tx = m_wave.pop_front();
            m_idle = 1'b0;
        end else begin
            m_tx = 1'b1;
            m_idle = 1'b1;
        end
    endtask

    task automatic tick(input logic v, input logic [4:0] d, input logic [31:0] x);
        wb_valid = v;
        wb_dest = d;
        wb_data = x;
        @(posedge clk);
        cyc++;
        model_step(v, d, x);
        @(negedge clk);
        check("tx", 40'(tx), 40'(m_tx));
        check("busy", 40'(busy), 40'(!m_idle || (m_q.size() != 0)));
        check("overflow", 40'(overflow), 40'(m_ovf));
        check("fifo_count", 40'(fifo_count), 40'(m_q.size()));
        if (rec_n < 4096) begin
            rec_tx[rec_n] = tx;
            rec_busy[rec_n] = busy;
            rec_n++;
        end
        wb_valid = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        repeat (n) tick(1'b0, 5'd0, 32'd0);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick(1'b0, 5'd0, 32'd0);
            n++;
        end
        check("drain_timeout", 40'(n < budget), 40'd1);
    endtask

    // Recover bytes from the recorded line by sampling mid-bit.
    task automatic decode();
        int i;
        logic [7:0] b;
        dec_q.delete();
        i = 0;
        while (i + 10*CPB <= rec_n) begin
            if (rec_tx[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = rec_tx[i + CPB*(k+1) + CPB/2];
                dec_q.push_back(b);
                i += 10*CPB;
            end else begin
                i++;
            end
        end
    endtask

    int s0, s1;
    logic [7:0] exp_bytes [5];

    initial begin
        // reset state
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_tx", 40'(tx), 40'd1);
        check("rst_busy", 40'(busy), 40'd0);
        check("rst_ovf", 40'(overflow), 40'd0);
        check("rst_count", 40'(fifo_count), 40'd0);
        rst_n = 1'b1;

        // writes to register 0 are ignored
        tick(1'b1, 5'd0, 32'h12345678);
        idle_ticks(3);
        check("r0_count", 40'(fifo_count), 40'd0);
        check("r0_tx", 40'(tx), 40'd1);
        check("r0_busy", 40'(busy), 40'd0);

        // single frame content and length
        rec_n = 0;
        tick(1'b1, 5'd5, 32'hDEADBEEF);
        idle_ticks(210);
        decode();
        exp_bytes = '{8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        check("single_nbytes", 40'(dec_q.size()), 40'd5);
        for (int k = 0; k < 5 && k < dec_q.size(); k++)
            check("single_byte", 40'(dec_q[k]), 40'(exp_bytes[k]));
        s0 = -1; s1 = -1;
        for (int i = 0; i < rec_n; i++) if (s0 < 0 && rec_tx[i] == 1'b0) s0 = i;
        for (int i = s0 + 1; i < rec_n && s0 >= 0; i++) if (s1 < 0 && rec_busy[i] == 1'b0) s1 = i;
        check("frame_start_idx", 40'(s0), 40'd1);
        check("frame_len", 40'(s1 - s0), 40'd200);

        // two queued entries: one idle cycle between frames
        rec_n = 0;
        tick(1'b1, 5'd7, 32'hA5A50F0F);
        tick(1'b1, 5'd9, 32'h01020304);
        drain(600);
        decode();
        check("b2b_nbytes", 40'(dec_q.size()), 40'd10);
        if (dec_q.size() >= 6) check("b2b_dest2", 40'(dec_q[5]), 40'h09);
        check("b2b_stop_end", 40'(rec_tx[200]), 40'd1);
        check("b2b_gap", 40'(rec_tx[201]), 40'd1);
        check("b2b_start2", 40'(rec_tx[202]), 40'd0);

        // six writes while idle: one in flight, four buffered, one dropped
        rec_n = 0;
        for (int i = 1; i <= 6; i++) tick(1'b1, 5'(i), $urandom());
        check("burst_ovf", 40'(overflow), 40'd1);
        check("burst_count", 40'(fifo_count), 40'd4);
        drain(1500);
        decode();
        check("burst_nbytes", 40'(dec_q.size()), 40'd25);
        for (int f = 0; f < 5 && 5*f < dec_q.size(); f++)
            check("burst_dest", 40'(dec_q[5*f]), 40'(f + 1));

        // reset during data bits of byte 2 with three entries queued
        tick(1'b1, 5'd1, 32'h00000000);
        for (int i = 2; i <= 4; i++) tick(1'b1, 5'(i), $urandom());
        check("pre_rst_count", 40'(fifo_count), 40'd3);
        idle_ticks(93);
        check("pre_rst_tx", 40'(tx), 40'd0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx", 40'(tx), 40'd1);
        check("midrst_busy", 40'(busy), 40'd0);
        check("midrst_count", 40'(fifo_count), 40'd0);
        check("midrst_ovf", 40'(overflow), 40'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rec_n = 0;
        idle_ticks(300);
        s0 = 0;
        for (int i = 0; i < rec_n; i++) if (rec_tx[i] == 1'b0) s0++;
        check("post_rst_quiet", 40'(s0), 40'd0);

        // full FIFO: push coinciding with the pop is accepted
        for (int i = 10; i <= 14; i++) tick(1'b1, 5'(i), $urandom());
        check("full_count", 40'(fifo_count), 40'd4);
        s1 = 0;
        while (!(m_idle && m_q.size() > 0) && s1 < 300) begin
            tick(1'b0, 5'd0, 32'd0);
            s1++;
        end
        check("pop_wait_timeout", 40'(s1 < 300), 40'd1);
        tick(1'b1, 5'd15, 32'hCAFEF00D);
        check("pushpop_count", 40'(fifo_count), 40'd4);
        check("pushpop_ovf", 40'(overflow), 40'd0);
        drain(1500);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 5)
                tick(1'b1, 5'($urandom_range(0, 31)), $urandom());
            else
                tick(1'b0, 5'($urandom_range(0, 31)), $urandom());
        end
        drain(1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
